// File: rtl/fifo_pkg.sv
// Shared constants and types for the floor-request FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_W = 4;
  localparam int FIFO_DEPTH  = 16;

  typedef logic [FIFO_DATA_W-1:0] word_t;

endpackage

// File: rtl/fifo_if.sv
// Handshake bundle between the request capture logic, the FIFO and the scheduler.
// The sticky error outputs exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
);

  logic [DATA_W-1:0] i_wr_data;
  logic              i_wr_en;
  logic              i_rd_en;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_fifo_full;
  logic              o_fifo_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic              o_overflow;
  logic              o_underflow;
`endif

  // Producer/consumer side
  modport master (
    output i_wr_data, i_wr_en, i_rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    input  o_overflow, o_underflow,
`endif
    input  o_rd_data, o_fifo_full, o_fifo_empty
  );

  // FIFO side
  modport slave (
    input  i_wr_data, i_wr_en, i_rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    output o_overflow, o_underflow,
`endif
    output o_rd_data, o_fifo_full, o_fifo_empty
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage array: synchronous write, asynchronous read address.
// Contents are never reset.
module fifo_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store the incoming word at the write address
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO for elevator floor-request codes.
// Pointers, occupancy count, flags and the registered read port live here;
// storage is in fifo_mem. Define FIFO_ERR_FLAGS_EN to add sticky
// overflow/underflow outputs.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic  i_clock,
  input  logic  i_rst,
  fifo_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem_rd_data;
  logic              full, empty;
  logic              wr_acc, rd_acc;

  // Flags decode the registered count, so both requests see pre-edge status
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.i_wr_en & ~full;
  assign rd_acc = bus.i_rd_en & ~empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i     (i_clock),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.i_wr_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rd_data)
  );

  // Next-state for pointers, occupancy and the read register
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_rd_data;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the queue but leaves storage untouched
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.o_rd_data    = rd_data_q;
  assign bus.o_fifo_full  = full;
  assign bus.o_fifo_empty = empty;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error detection, cleared only by reset
  always_comb begin
    ovf_d = ovf_q | (bus.i_wr_en & full);
    unf_d = unf_q | (bus.i_rd_en & empty);
  end

  // Error flag registers
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed bench for the floor-request FIFO.
module tb_fifo;
  import fifo_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fifo_if #(.DATA_W(FIFO_DATA_W)) bus ();

  fifo #(
    .DATA_W (FIFO_DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) dut (
    .i_clock (clk),
    .i_rst   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge
  task automatic cycle(input logic wr, input word_t d, input logic rd);
    @(negedge clk);
    bus.i_wr_en   = wr;
    bus.i_wr_data = d;
    bus.i_rd_en   = rd;
    @(posedge clk);
    #1;
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.i_wr_en   = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus.i_wr_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_empty", 32'(bus.o_fifo_empty), 32'd1);
    chk("rst_full",  32'(bus.o_fifo_full),  32'd0);
    chk("rst_data",  32'(bus.o_rd_data),    32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_ovf", 32'(bus.o_overflow),  32'd0);
    chk("rst_unf", 32'(bus.o_underflow), 32'd0);
`endif

    // Fill 0..15
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, word_t'(i), 1'b0);
      if (i == 0)  chk("fill_first_empty", 32'(bus.o_fifo_empty), 32'd0);
      if (i == 14) chk("fill_15_full",     32'(bus.o_fifo_full),  32'd0);
    end
    chk("fill_full",  32'(bus.o_fifo_full),  32'd1);
    chk("fill_empty", 32'(bus.o_fifo_empty), 32'd0);
    cycle(1'b1, 4'hA, 1'b0);
    chk("ovf_write_full", 32'(bus.o_fifo_full), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_flag", 32'(bus.o_overflow), 32'd1);
`endif

    // Drain with alternating read requests
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("drain_data", 32'(bus.o_rd_data), 32'(i));
      if (i == 0) chk("drain_full_drop", 32'(bus.o_fifo_full), 32'd0);
      if (i < 15) chk("drain_not_empty", 32'(bus.o_fifo_empty), 32'd0);
      cycle(1'b0, '0, 1'b0);
      chk("drain_hold", 32'(bus.o_rd_data), 32'(i));
    end
    chk("drain_empty", 32'(bus.o_fifo_empty), 32'd1);

    // Read while empty
    cycle(1'b0, '0, 1'b1);
    chk("unf_data",  32'(bus.o_rd_data),    32'd15);
    chk("unf_empty", 32'(bus.o_fifo_empty), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("unf_flag", 32'(bus.o_underflow), 32'd1);
`endif

    // Simultaneous read/write with 5 stored
    for (int i = 1; i <= 5; i++) cycle(1'b1, word_t'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, word_t'(6 + i), 1'b1);
      chk("simul_data",  32'(bus.o_rd_data),    32'(1 + i));
      chk("simul_empty", 32'(bus.o_fifo_empty), 32'd0);
      chk("simul_full",  32'(bus.o_fifo_full),  32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("simul_tail", 32'(bus.o_rd_data), 32'(5 + i));
      if (i < 4) chk("simul_tail_nonempty", 32'(bus.o_fifo_empty), 32'd0);
    end
    chk("simul_tail_empty", 32'(bus.o_fifo_empty), 32'd1);

    // Simultaneous at empty: only the write lands
    cycle(1'b1, 4'hC, 1'b1);
    chk("simul_e_data",  32'(bus.o_rd_data),    32'd9);
    chk("simul_e_empty", 32'(bus.o_fifo_empty), 32'd0);
    cycle(1'b0, '0, 1'b1);
    chk("simul_e_read",  32'(bus.o_rd_data),    32'hC);
    chk("simul_e_drain", 32'(bus.o_fifo_empty), 32'd1);

    // Wrap: write 10, read 10, write 12, read 12
    for (int i = 0; i < 10; i++) cycle(1'b1, word_t'(i + 3), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("wrap1_data", 32'(bus.o_rd_data), 32'((i + 3) & 15));
    end
    chk("wrap1_empty", 32'(bus.o_fifo_empty), 32'd1);
    for (int i = 0; i < 12; i++) cycle(1'b1, word_t'(15 - i), 1'b0);
    chk("wrap2_full", 32'(bus.o_fifo_full), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("wrap2_data", 32'(bus.o_rd_data), 32'(15 - i));
    end
    chk("wrap2_empty", 32'(bus.o_fifo_empty), 32'd1);

    // Mid-cycle asynchronous reset with 3 stored
    for (int i = 1; i <= 3; i++) cycle(1'b1, word_t'(i), 1'b0);
    chk("mrst_pre_empty", 32'(bus.o_fifo_empty), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_empty", 32'(bus.o_fifo_empty), 32'd1);
    chk("mrst_full",  32'(bus.o_fifo_full),  32'd0);
    chk("mrst_data",  32'(bus.o_rd_data),    32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("mrst_ovf", 32'(bus.o_overflow),  32'd0);
    chk("mrst_unf", 32'(bus.o_underflow), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b1);
    chk("post_rst_data",  32'(bus.o_rd_data),    32'd0);
    chk("post_rst_empty", 32'(bus.o_fifo_empty), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("post_rst_unf", 32'(bus.o_underflow), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock FIFO queue for the elevator controller; buffers 4-bit floor-request codes between the request capture logic and the lift scheduler.
- Writes and reads share one clock.
- Full and empty status flags let producer and consumer throttle themselves.

Parameters:
- DATA_W, 4, width of each stored word (floor code).
- DEPTH, 16, number of storage entries; must be a power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- i_clock  input  1  rising-edge clock for all state.
- i_rst  input  1  asynchronous active-high reset.
- i_wr_data  input  DATA_W  word to enqueue.
- i_wr_en  input  1  write request, sampled on the rising edge.
- i_rd_en  input  1  read request, sampled on the rising edge.
- o_rd_data  output  DATA_W  registered read data.
- o_fifo_full  output  1  high when DEPTH words are stored.
- o_fifo_empty  output  1  high when 0 words are stored.

Behaviour:
- Reset (i_rst=1, async assert, sync-safe deassert):
  - write pointer, read pointer and count = 0;
  - o_rd_data = 0;
  - o_fifo_empty = 1, o_fifo_full = 0.
  - Memory contents are not cleared.
- State: wr_ptr and rd_ptr (ADDR_W bits, wrap modulo DEPTH) plus count (ADDR_W+1 bits, range 0..DEPTH).
- Accepted write, when i_wr_en=1 and o_fifo_full=0 before the edge:
  - mem[wr_ptr] <= i_wr_data;
  - wr_ptr increments.
- Accepted read, when i_rd_en=1 and o_fifo_empty=0 before the edge:
  - o_rd_data <= mem[rd_ptr];
  - rd_ptr increments.
  - Read latency is 1 clock: data is valid after the edge that sampled i_rd_en.
- o_rd_data holds its last value when no read is accepted.
- Write while full: ignored; data dropped; no state change.
- Read while empty: ignored; o_rd_data unchanged.
- Simultaneous read and write:
  - Each request is judged on the pre-edge flags.
  - Both accepted: count unchanged; both pointers advance.
  - Empty: only the write is accepted.
  - Full: only the read is accepted.
- Count update: +1 on write only, -1 on read only, unchanged otherwise.
- Flags are combinational decodes of the registered count: full = (count==DEPTH), empty = (count==0).
- Pointer wrap: DEPTH-1 -> 0 with no gap; ordering is strictly first-in, first-out across the wrap.
- Reset mid-operation empties the FIFO immediately; stored words are lost.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, two extra output ports are added:
  - o_overflow: sticky, set on any write attempted while full.
  - o_underflow: sticky, set on any read attempted while empty.
  - Both are cleared only by i_rst.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_pkg: DATA_W and DEPTH default constants, and a typedef for the data word.
- One sub-module, fifo_mem: a DEPTH x DATA_W register array with a synchronous write port and an asynchronous read address. It is instantiated by fifo.
- Pointers, count, flags and the output register stay in fifo.

Test Plan:
- Reset: pulse i_rst for 1 cycle -> o_fifo_empty=1, o_fifo_full=0, o_rd_data=0.
- Fill: write 0..15 on 16 consecutive edges -> o_fifo_full=1 after the 16th edge, o_fifo_empty=0. A 17th write of 4'hA is ignored.
- Drain: 16 reads alternating i_rd_en 1/0 -> o_rd_data sequence 0,1,...,15, each valid one edge after its request. o_fifo_full drops after the first read; o_fifo_empty=1 after the 16th read.
- Underflow: extra read when empty -> o_rd_data stays 15, pointers unchanged. With FIFO_ERR_FLAGS_EN, o_underflow=1.
- Simultaneous: with 5 words stored, assert i_wr_en and i_rd_en together for 4 cycles -> count remains 5 and output order is preserved. Repeat at empty: only the write is taken, count=1.
- Wrap and mid-reset: write 10, read 10, write 12 (wrapping the pointers), read all -> order intact. Then write 3, assert i_rst mid-cycle -> empty flag asserts asynchronously and subsequent reads return nothing new.
